// File: rtl/ls1u_pkg.sv
// Shared types and constants for the LS1u interrupt controller and context stack.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ls1u_pkg;

  // Widths of one saved context. The controller's ADDR_W/DATA_W must match these.
  localparam int CTX_PC_W   = 24;
  localparam int CTX_DATA_W = 8;
  localparam int PRIO_W     = 3;   // up to 8 sources
  localparam int SP_W       = 4;   // depth 0..8 fits, and matches STAT[3:0]

  // XCR register addresses
  localparam logic [7:0] XCR_IE   = 8'h00;
  localparam logic [7:0] XCR_PEND = 8'h01;
  localparam logic [7:0] XCR_STAT = 8'h02;
  localparam logic [7:0] XCR_PRIO = 8'h03;
  localparam logic [7:0] XCR_RET0 = 8'h04;
  localparam logic [7:0] XCR_RET1 = 8'h05;
  localparam logic [7:0] XCR_RET2 = 8'h06;
  localparam logic [7:0] XCR_RTA0 = 8'h07;
  localparam logic [7:0] XCR_RTA1 = 8'h08;
  localparam logic [7:0] XCR_RTA2 = 8'h09;

  // STAT register bit positions
  localparam int STAT_ERR_BIT = 7;
  localparam int STAT_GIE_BIT = 6;

  // One saved context: return PC, accumulators and the priority that was taken
  typedef struct packed {
    logic [CTX_PC_W-1:0]   pc;
    logic [CTX_DATA_W-1:0] a2;
    logic [CTX_DATA_W-1:0] a1;
    logic [CTX_DATA_W-1:0] a0;
    logic [PRIO_W-1:0]     prio;
  } ctx_t;

endpackage

// File: rtl/ls1u_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
// Latency: purely combinational.
// Backpressure: none.
module ls1u_prio_enc #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top down so the lowest set index is the last one assigned
  always_comb begin
    vld_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/ls1u_ctx_intc.sv
// Nested prioritised interrupt controller with a hardware return-context stack.
// Latency: irq_i to take_o one cycle (registered pend); take_o/vec_o/ret_* combinational.
// Backpressure: core_stall_i blocks push/pop; requests stay pending while the stack is full.
// Build option LS1U_INTC_EDGE_EN: pend latches rising edges instead of following levels.
module ls1u_ctx_intc
  import ls1u_pkg::*;
#(
  parameter int                 NUM_IRQ         = 8,
  parameter int                 STACK_DEPTH     = 4,
  parameter int                 ADDR_W          = CTX_PC_W,
  parameter int                 DATA_W          = CTX_DATA_W,
  parameter logic [ADDR_W-1:0]  VEC_BASE        = 24'h000100,
  parameter int                 VEC_STRIDE_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IRQ-1:0]    irq_i,
  input  logic                  core_stall_i,
  input  logic [ADDR_W-1:0]     save_pc_i,
  input  logic [3*DATA_W-1:0]   save_a_i,
  input  logic                  ret_i,
  output logic                  take_o,
  output logic [ADDR_W-1:0]     vec_o,
  output logic [ADDR_W-1:0]     ret_pc_o,
  output logic [3*DATA_W-1:0]   ret_a_o,
  output logic                  in_isp_o,
  input  logic                  xcr_cs_i,
  input  logic                  xcr_we_i,
  input  logic [7:0]            xcr_addr_i,
  input  logic [DATA_W-1:0]     xcr_wdata_i,
  output logic [DATA_W-1:0]     xcr_rdata_o
);

  logic [NUM_IRQ-1:0] ie_q, ie_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic               gie_q, gie_d;
  logic               err_q, err_d;
  ctx_t               stack_q [STACK_DEPTH];

  ctx_t               top;
  ctx_t               push_ctx;
  ctx_t               top_wr_ctx;
  logic               win_vld;
  logic [PRIO_W-1:0]  win_idx;
  logic               empty, full;
  logic               push, pop, ret_err;
  logic               xcr_wr, top_wr;

  ls1u_prio_enc #(.N(NUM_IRQ), .IW(PRIO_W)) u_prio (
    .req_i (pend_q),
    .vld_o (win_vld),
    .idx_o (win_idx)
  );

  assign empty   = (sp_q == '0);
  assign full    = (sp_q >= SP_W'(STACK_DEPTH));
  assign xcr_wr  = xcr_cs_i & xcr_we_i;

  // Asynchronous top-of-stack read; all zeros when the stack is empty
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) top = stack_q[i];
    end
  end

  // Take decision: a RET in flight always beats a new take; only strictly higher priority nests
  always_comb begin
    take_o = gie_q & win_vld & ~full & ~ret_i & (empty | (win_idx < top.prio));
    vec_o  = take_o ? (VEC_BASE + (ADDR_W'(win_idx) << VEC_STRIDE_LOG2)) : '0;
  end

  assign push     = take_o & ~core_stall_i;
  assign pop      = ret_i & ~core_stall_i & ~empty;
  assign ret_err  = ret_i & ~core_stall_i & empty;
  assign top_wr   = xcr_wr & ~empty & ~push & ~pop &
                    (xcr_addr_i >= XCR_RET0) & (xcr_addr_i <= XCR_RTA2);

  assign in_isp_o = ~empty;
  assign ret_pc_o = top.pc;
  assign ret_a_o  = {top.a2, top.a1, top.a0};

  // Build the context to push and the patched top entry for software byte writes
  always_comb begin
    push_ctx      = '0;
    push_ctx.pc   = save_pc_i;
    push_ctx.a2   = save_a_i[3*DATA_W-1:2*DATA_W];
    push_ctx.a1   = save_a_i[2*DATA_W-1:DATA_W];
    push_ctx.a0   = save_a_i[DATA_W-1:0];
    push_ctx.prio = win_idx;
    top_wr_ctx    = top;
    case (xcr_addr_i)
      XCR_RET0: top_wr_ctx.pc[7:0]   = xcr_wdata_i;
      XCR_RET1: top_wr_ctx.pc[15:8]  = xcr_wdata_i;
      XCR_RET2: top_wr_ctx.pc[23:16] = xcr_wdata_i;
      XCR_RTA0: top_wr_ctx.a0        = xcr_wdata_i;
      XCR_RTA1: top_wr_ctx.a1        = xcr_wdata_i;
      XCR_RTA2: top_wr_ctx.a2        = xcr_wdata_i;
      default: ;
    endcase
  end

  // Control register next state: enables, global enable, sticky error, stack pointer
  always_comb begin
    ie_d  = ie_q;
    gie_d = gie_q;
    err_d = err_q;
    sp_d  = sp_q;
    if (xcr_wr && xcr_addr_i == XCR_IE) ie_d = xcr_wdata_i[NUM_IRQ-1:0];
    if (xcr_wr && xcr_addr_i == XCR_STAT) begin
      gie_d = xcr_wdata_i[STAT_GIE_BIT];
      if (xcr_wdata_i[STAT_ERR_BIT]) err_d = 1'b0;
    end
    if (ret_err) err_d = 1'b1;
    if (push)     sp_d = sp_q + SP_W'(1);
    else if (pop) sp_d = sp_q - SP_W'(1);
  end

`ifdef LS1U_INTC_EDGE_EN
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] rise, take_clr, sw_clr;

  // Edge mode: latch enabled rising edges, clear on take or software write-1-to-clear
  always_comb begin
    rise     = irq_i & ~irq_prev_q & ie_q;
    take_clr = push ? (NUM_IRQ'(1) << win_idx) : '0;
    sw_clr   = (xcr_wr && xcr_addr_i == XCR_PEND) ? xcr_wdata_i[NUM_IRQ-1:0] : '0;
    pend_d   = (pend_q & ~take_clr & ~sw_clr) | rise;
  end

  // Previous irq level for edge detection
  always_ff @(posedge clk) begin
    if (rst) irq_prev_q <= '0;
    else     irq_prev_q <= irq_i;
  end
`else
  // Level mode: pend simply follows the enabled request lines one cycle late
  always_comb begin
    pend_d = irq_i & ie_q;
  end
`endif

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q   <= '0;
      pend_q <= '0;
      sp_q   <= '0;
      gie_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      pend_q <= pend_d;
      sp_q   <= sp_d;
      gie_q  <= gie_d;
      err_q  <= err_d;
    end
  end

  // Context stack: push writes slot sp, software patches slot sp-1
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push && sp_q == SP_W'(i))                stack_q[i] <= push_ctx;
        else if (top_wr && sp_q == SP_W'(i + 1))     stack_q[i] <= top_wr_ctx;
      end
    end
  end

  // XCR read mux; unmapped addresses and deselected bus read zero
  always_comb begin
    xcr_rdata_o = '0;
    if (xcr_cs_i) begin
      case (xcr_addr_i)
        XCR_IE:   xcr_rdata_o = DATA_W'(ie_q);
        XCR_PEND: xcr_rdata_o = DATA_W'(pend_q);
        XCR_STAT: begin
          xcr_rdata_o[STAT_ERR_BIT] = err_q;
          xcr_rdata_o[STAT_GIE_BIT] = gie_q;
          xcr_rdata_o[3:0]          = sp_q;
        end
        XCR_PRIO: xcr_rdata_o = empty ? 8'hFF : DATA_W'(top.prio);
        XCR_RET0: xcr_rdata_o = top.pc[7:0];
        XCR_RET1: xcr_rdata_o = top.pc[15:8];
        XCR_RET2: xcr_rdata_o = top.pc[23:16];
        XCR_RTA0: xcr_rdata_o = top.a0;
        XCR_RTA1: xcr_rdata_o = top.a1;
        XCR_RTA2: xcr_rdata_o = top.a2;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_ls1u_ctx_intc.sv
// Directed bench for ls1u_ctx_intc: take/vector, nesting, full stack, RET error, stall, XCR.
// Latency: inputs driven 2 time units after posedge, outputs sampled 1 unit later.
// Backpressure: exercised through core_stall_i and a full stack.
module tb_ls1u_ctx_intc;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_i;
  logic        core_stall_i;
  logic [23:0] save_pc_i;
  logic [23:0] save_a_i;
  logic        ret_i;
  logic        take_o;
  logic [23:0] vec_o;
  logic [23:0] ret_pc_o;
  logic [23:0] ret_a_o;
  logic        in_isp_o;
  logic        xcr_cs_i;
  logic        xcr_we_i;
  logic [7:0]  xcr_addr_i;
  logic [7:0]  xcr_wdata_i;
  logic [7:0]  xcr_rdata_o;

  int n_tot = 0;
  int n_bad = 0;
  logic [7:0] rd;

  ls1u_ctx_intc dut (
    .clk          (clk),
    .rst          (rst),
    .irq_i        (irq_i),
    .core_stall_i (core_stall_i),
    .save_pc_i    (save_pc_i),
    .save_a_i     (save_a_i),
    .ret_i        (ret_i),
    .take_o       (take_o),
    .vec_o        (vec_o),
    .ret_pc_o     (ret_pc_o),
    .ret_a_o      (ret_a_o),
    .in_isp_o     (in_isp_o),
    .xcr_cs_i     (xcr_cs_i),
    .xcr_we_i     (xcr_we_i),
    .xcr_addr_i   (xcr_addr_i),
    .xcr_wdata_i  (xcr_wdata_i),
    .xcr_rdata_o  (xcr_rdata_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic xcr_write(input logic [7:0] a, input logic [7:0] d);
    xcr_cs_i = 1'b1; xcr_we_i = 1'b1; xcr_addr_i = a; xcr_wdata_i = d;
    step();
    xcr_cs_i = 1'b0; xcr_we_i = 1'b0;
  endtask

  task automatic xcr_read(input logic [7:0] a, output logic [7:0] d);
    xcr_cs_i = 1'b1; xcr_we_i = 1'b0; xcr_addr_i = a;
    #1;
    d = xcr_rdata_o;
    xcr_cs_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_i = '0; core_stall_i = 1'b0; save_pc_i = '0; save_a_i = '0;
    ret_i = 1'b0; xcr_cs_i = 1'b0; xcr_we_i = 1'b0; xcr_addr_i = '0; xcr_wdata_i = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_take", take_o, 0);
    chk("rst_vec", vec_o, 0);
    chk("rst_isp", in_isp_o, 0);
    chk("rst_retpc", ret_pc_o, 0);
    chk("rst_reta", ret_a_o, 0);
    xcr_read(8'h02, rd); chk("rst_stat", rd, 8'h00);
    xcr_read(8'h03, rd); chk("rst_prio", rd, 8'hFF);
    xcr_read(8'h00, rd); chk("rst_ie", rd, 8'h00);

    // 1: single take of source 2
    xcr_write(8'h00, 8'h04);
    xcr_write(8'h02, 8'h40);
    irq_i = 8'h04; save_pc_i = 24'h001234; save_a_i = 24'h332211;
    #1; chk("t1_take_early", take_o, 0);
    step();
    chk("t1_take", take_o, 1);
    chk("t1_vec", vec_o, 24'h000120);
    step();
    xcr_read(8'h02, rd); chk("t1_stat", rd, 8'h41);
    xcr_read(8'h03, rd); chk("t1_prio", rd, 8'h02);
    chk("t1_retpc", ret_pc_o, 24'h001234);
    chk("t1_reta", ret_a_o, 24'h332211);
    xcr_read(8'h07, rd); chk("t1_rta0", rd, 8'h11);
    chk("t1_no_retake", take_o, 0);

    // 2: lower priority does not nest, higher priority does
    xcr_write(8'h00, 8'h25);
    irq_i = 8'h24;
    step(); chk("t2_low_notake", take_o, 0);
    irq_i = 8'h25; save_pc_i = 24'h000500; save_a_i = 24'h665544;
    step();
    chk("t2_take", take_o, 1);
    chk("t2_vec", vec_o, 24'h000100);
    step();
    xcr_read(8'h03, rd); chk("t2_prio", rd, 8'h00);
    xcr_read(8'h02, rd); chk("t2_stat", rd, 8'h42);
    irq_i = '0;
    step();

    // 6: software patches the top entry
    xcr_write(8'h05, 8'hAB);
    chk("t6_retpc", ret_pc_o, 24'h00AB00);
    xcr_read(8'h05, rd); chk("t6_ret1", rd, 8'hAB);
    chk("t6_reta", ret_a_o, 24'h665544);

    // Pops: outputs show the entry being popped until the edge
    ret_i = 1'b1; #1;
    chk("pop_pre_pc", ret_pc_o, 24'h00AB00);
    step(); ret_i = 1'b0; #1;
    chk("pop1_pc", ret_pc_o, 24'h001234);
    ret_i = 1'b1; step(); ret_i = 1'b0; #1;
    chk("pop2_isp", in_isp_o, 0);
    chk("pop2_pc", ret_pc_o, 0);
    xcr_read(8'h03, rd); chk("pop2_prio", rd, 8'hFF);

    // 4: RET on empty stack sets sticky err
    ret_i = 1'b1; step(); ret_i = 1'b0;
    xcr_read(8'h02, rd); chk("t4_stat_err", rd, 8'hC0);
    chk("t4_isp", in_isp_o, 0);
    xcr_write(8'h02, 8'h80);
    xcr_read(8'h02, rd); chk("t4_err_clr", {31'd0, rd[7]}, 0);
    xcr_write(8'h02, 8'h40);
    xcr_read(8'h02, rd); chk("t4_gie", rd, 8'h40);

    // 3: fill the stack with sources 3,2,1,0
    xcr_write(8'h00, 8'h0F);
    for (int k = 3; k >= 0; k--) begin
      irq_i[k] = 1'b1; save_pc_i = 24'h000010 + 24'(k);
      step();
      chk("t3_take", take_o, 1);
      chk("t3_vec", vec_o, 24'h000100 + 24'(k * 16));
      step();
      xcr_read(8'h02, rd); chk("t3_sp", rd, 8'h40 + 8'(4 - k));
    end
    irq_i = '0; step();
    irq_i = 8'h01; step();
    chk("t3_full_notake", take_o, 0);
    step();
    chk("t3_full_notake2", take_o, 0);
    xcr_read(8'h02, rd); chk("t3_full_stat", rd, 8'h44);
    ret_i = 1'b1; #1;
    chk("t3_ret_notake", take_o, 0);
    step(); ret_i = 1'b0; #1;
    chk("t3_after_ret_take", take_o, 1);
    chk("t3_after_ret_vec", vec_o, 24'h000100);
    step();
    xcr_read(8'h02, rd); chk("t3_refill", rd, 8'h44);
    irq_i = '0; step();
    for (int k = 0; k < 4; k++) begin
      ret_i = 1'b1; step(); ret_i = 1'b0;
    end
    xcr_read(8'h02, rd); chk("t3_drain", rd, 8'h40);

    // 5: RET and pending request in the same cycle; stall blocks push and pop
    irq_i = 8'h08; step(); step();
    xcr_read(8'h02, rd); chk("t5_sp1", rd, 8'h41);
    irq_i = 8'h02; step();
    ret_i = 1'b1; #1;
    chk("t5_ret_blocks_take", take_o, 0);
    step(); ret_i = 1'b0; #1;
    chk("t5_take_next", take_o, 1);
    chk("t5_vec", vec_o, 24'h000110);
    xcr_read(8'h02, rd); chk("t5_popped", rd, 8'h40);
    core_stall_i = 1'b1; step();
    xcr_read(8'h02, rd); chk("t5_stall_nopush", rd, 8'h40);
    chk("t5_stall_take", take_o, 1);
    core_stall_i = 1'b0; step();
    xcr_read(8'h02, rd); chk("t5_push", rd, 8'h41);
    irq_i = '0; ret_i = 1'b1; core_stall_i = 1'b1; step();
    xcr_read(8'h02, rd); chk("t5_stall_nopop", rd, 8'h41);
    core_stall_i = 1'b0; step(); ret_i = 1'b0;
    xcr_read(8'h02, rd); chk("t5_pop", rd, 8'h40);

`ifdef LS1U_INTC_EDGE_EN
    // Edge capture: one-cycle pulse held until software clears or it is taken
    xcr_write(8'h02, 8'h00);
    xcr_write(8'h00, 8'h08);
    irq_i = 8'h08; step(); irq_i = '0; step(); step();
    xcr_read(8'h01, rd); chk("edge_pend", rd, 8'h08);
    xcr_write(8'h01, 8'h08);
    xcr_read(8'h01, rd); chk("edge_sw_clr", rd, 8'h00);
    irq_i = 8'h08; step(); irq_i = '0; step();
    xcr_read(8'h01, rd); chk("edge_pend2", rd, 8'h08);
    xcr_write(8'h02, 8'h40);
    chk("edge_take", take_o, 1);
    chk("edge_vec", vec_o, 24'h000130);
    step();
    xcr_read(8'h01, rd); chk("edge_take_clr", rd, 8'h00);
    xcr_read(8'h02, rd); chk("edge_sp", rd, 8'h41);
    ret_i = 1'b1; step(); ret_i = 1'b0;
`else
    // Level mode: a pulse that ends before being taken is dropped
    xcr_write(8'h02, 8'h00);
    xcr_write(8'h00, 8'h08);
    irq_i = 8'h08; step();
    xcr_read(8'h01, rd); chk("lvl_pend", rd, 8'h08);
    irq_i = '0; step();
    xcr_read(8'h01, rd); chk("lvl_dropped", rd, 8'h00);
    chk("lvl_notake", take_o, 0);
    xcr_write(8'h02, 8'h40);
`endif

    // Unmapped address reads zero
    xcr_read(8'h20, rd); chk("unmapped", rd, 8'h00);

    // Reset in the middle of an ISR discards the stack
    xcr_write(8'h00, 8'h01);
    irq_i = 8'h01; step(); step();
    chk("isr_active", in_isp_o, 1);
    rst = 1'b1; step(); rst = 1'b0; irq_i = '0; #1;
    chk("rst_mid_isp", in_isp_o, 0);
    chk("rst_mid_pc", ret_pc_o, 0);
    xcr_read(8'h00, rd); chk("rst_mid_ie", rd, 8'h00);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
